// File: rtl/rv32_types.sv
// ============================================================================
// Module      : rv32_types (package)
// Description : Shared RV32 core types and constants: register id type,
//               register-file read-port count and the long-op response record
//               carried from the long-latency units back to writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32_types;

    // Number of source operands decode can present in one instruction.
    localparam int CORE_RF_NUM_READ = 3;

    // Long-latency operations that may be issued but not yet retired.
    localparam int LONG_OP_MAX_OUTSTANDING = 4;

    typedef logic [4:0] rv_reg_id_t;

    typedef struct packed {
        rv_reg_id_t  rd;
        logic [31:0] data;
    } long_resp_t;

endpackage

`default_nettype wire

// File: rtl/rv32_resp_fifo.sv
// ============================================================================
// Module      : rv32_resp_fifo
// Description : Synchronous FIFO of long_resp_t records with full/empty flags
//               and asynchronous active-high reset. A push while full and a
//               pop while empty are ignored.
// Ports       : clk, reset        - clock, async active-high reset
//               push, push_data   - write request and record
//               pop               - remove the head record
//               head              - current head record (valid when !empty)
//               full, empty       - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32_resp_fifo
    import rv32_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  long_resp_t push_data,
    input  logic       pop,
    output long_resp_t head,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(DEPTH);

    long_resp_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Storage carries no reset; the head is only consumed while !empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == C_LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == C_LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign full  = (r_count == C_DEPTH);
    assign empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/rv32_long_op_scoreboard.sv
// ============================================================================
// Module      : rv32_long_op_scoreboard
// Description : Decode-stage scoreboard for long-latency operations. Tracks
//               pending destination registers, stalls decode on RAW/WAW
//               hazards and on the outstanding-op limit, buffers long-unit
//               responses and arbitrates the single RF write port between
//               pipeline writeback and buffered responses with a starvation
//               guard.
// Ports       : clk, reset                    - clock, async active-high reset
//               dec_rs/use_rs/rd/writes_rd/is_long/advance - decode view
//               stall                         - hazard stall to decode
//               lu_resp_valid/ready/rd/data   - long-unit response handshake
//               pipe_wb_en/rd/data            - pipeline writeback request
//               pipe_hold                     - pipeline WB must retry
//               rf_we/waddr/wdata             - register-file write port
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32_long_op_scoreboard
    import rv32_types::*;
#(
    parameter int NUM_READ        = CORE_RF_NUM_READ,
    parameter int MAX_OUTSTANDING = LONG_OP_MAX_OUTSTANDING,
    parameter int RESP_DEPTH      = 2,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  rv_reg_id_t [NUM_READ-1:0] dec_rs,
    input  logic [NUM_READ-1:0]       dec_use_rs,
    input  rv_reg_id_t                dec_rd,
    input  logic                      dec_writes_rd,
    input  logic                      dec_is_long,
    input  logic                      dec_advance,
    output logic                      stall,
    input  logic                      lu_resp_valid,
    output logic                      lu_resp_ready,
    input  rv_reg_id_t                lu_resp_rd,
    input  logic [31:0]               lu_resp_data,
    input  logic                      pipe_wb_en,
    input  rv_reg_id_t                pipe_wb_rd,
    input  logic [31:0]               pipe_wb_data,
    output logic                      pipe_hold,
    output logic                      rf_we,
    output rv_reg_id_t                rf_waddr,
    output logic [31:0]               rf_wdata
);

    localparam int OUT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [OUT_W-1:0]    C_OUT_MAX    = OUT_W'(MAX_OUTSTANDING);
    localparam logic [STARVE_W-1:0] C_STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [31:0]         r_pend;
    logic [OUT_W-1:0]    r_outstanding;
    logic [STARVE_W-1:0] r_starve;

    logic [31:0] w_pend_next;
    long_resp_t  w_push_data;
    long_resp_t  w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_issue_long;
    logic        w_head_zero;
    logic        w_force;

    assign w_issue_long  = dec_advance & dec_is_long;
    assign w_push        = lu_resp_valid & ~w_full;
    assign w_push_data   = '{rd: lu_resp_rd, data: lu_resp_data};
    assign lu_resp_ready = ~w_full;
    assign w_head_zero   = ~w_empty & (w_head.rd == 5'd0);
    assign w_force       = ~w_empty & (r_starve == C_STARVE_MAX);

    rv32_resp_fifo #(
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    // ------------------------------------------------------------------
    // Hazard stall: purely from registered pend/outstanding plus decode.
    // ------------------------------------------------------------------
    always_comb begin
        stall = 1'b0;
        for (int i = 0; i < NUM_READ; i++) begin
            if (dec_use_rs[i] && r_pend[dec_rs[i]]) begin
                stall = 1'b1;
            end
        end
        if (dec_writes_rd && r_pend[dec_rd]) begin
            stall = 1'b1;
        end
        if (dec_is_long && (r_outstanding == C_OUT_MAX)) begin
            stall = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write-port arbitration. An x0 head is discarded without using the
    // RF, so it never holds the pipeline back even when it would force.
    // ------------------------------------------------------------------
    always_comb begin
        w_pop     = 1'b0;
        pipe_hold = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        if (w_head_zero) begin
            w_pop = 1'b1;
            if (pipe_wb_en) begin
                rf_we    = 1'b1;
                rf_waddr = pipe_wb_rd;
                rf_wdata = pipe_wb_data;
            end
        end else if (w_force) begin
            w_pop     = 1'b1;
            pipe_hold = 1'b1;
            rf_we     = 1'b1;
            rf_waddr  = w_head.rd;
            rf_wdata  = w_head.data;
        end else if (pipe_wb_en) begin
            rf_we    = 1'b1;
            rf_waddr = pipe_wb_rd;
            rf_wdata = pipe_wb_data;
        end else if (!w_empty) begin
            w_pop    = 1'b1;
            rf_we    = 1'b1;
            rf_waddr = w_head.rd;
            rf_wdata = w_head.data;
        end
        // Keep the RF quiet while reset is asserted even if WB is requested.
        if (reset) begin
            pipe_hold = 1'b0;
            rf_we     = 1'b0;
            rf_waddr  = '0;
            rf_wdata  = '0;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard next state. Set and clear never target the same register
    // in one cycle: the WAW stall keeps a pending rd from being re-issued.
    // ------------------------------------------------------------------
    always_comb begin
        w_pend_next = r_pend;
        if (w_pop && !w_head_zero) begin
            w_pend_next[w_head.rd] = 1'b0;
        end
        if (w_issue_long && dec_writes_rd && (dec_rd != 5'd0)) begin
            w_pend_next[dec_rd] = 1'b1;
        end
        w_pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend        <= '0;
            r_outstanding <= '0;
            r_starve      <= '0;
        end else begin
            r_pend <= w_pend_next;

            case ({w_issue_long, w_pop})
                2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            // A non-empty buffer that did not pop was blocked by the pipeline.
            if (w_empty || w_pop) begin
                r_starve <= '0;
            end else if (r_starve != C_STARVE_MAX) begin
                r_starve <= r_starve + STARVE_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Protocol checks on the surrounding units.
    // ------------------------------------------------------------------
    a_resp_pending: assert property (@(posedge clk) disable iff (reset)
        (w_push && (lu_resp_rd != 5'd0)) |-> r_pend[lu_resp_rd]);

    a_wb_not_pending: assert property (@(posedge clk) disable iff (reset)
        pipe_wb_en |-> !r_pend[pipe_wb_rd]);

endmodule

`default_nettype wire

// File: tb/tb_rv32_long_op_scoreboard.sv
// ============================================================================
// Module      : tb_rv32_long_op_scoreboard
// Description : Randomised self-checking bench. A transaction-level model
//               (pending set, response queue, head wait count) predicts the
//               stall/hold/ready outputs each cycle and the RF writes, which
//               go into a queue checked by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32_long_op_scoreboard;
    import rv32_types::*;

    localparam int NR    = 3;
    localparam int MAXO  = 4;
    localparam int DEPTH = 2;
    localparam int LIM   = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0][4:0] dec_rs;
    logic [NR-1:0]     dec_use_rs;
    logic [4:0]        dec_rd;
    logic              dec_writes_rd;
    logic              dec_is_long;
    logic              dec_advance;
    logic              stall;
    logic              lu_resp_valid;
    logic              lu_resp_ready;
    logic [4:0]        lu_resp_rd;
    logic [31:0]       lu_resp_data;
    logic              pipe_wb_en;
    logic [4:0]        pipe_wb_rd;
    logic [31:0]       pipe_wb_data;
    logic              pipe_hold;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       rf_wdata;

    always #5 clk = ~clk;

    rv32_long_op_scoreboard #(
        .NUM_READ        (NR),
        .MAX_OUTSTANDING (MAXO),
        .RESP_DEPTH      (DEPTH),
        .STARVE_LIMIT    (LIM)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .dec_rs        (dec_rs),
        .dec_use_rs    (dec_use_rs),
        .dec_rd        (dec_rd),
        .dec_writes_rd (dec_writes_rd),
        .dec_is_long   (dec_is_long),
        .dec_advance   (dec_advance),
        .stall         (stall),
        .lu_resp_valid (lu_resp_valid),
        .lu_resp_ready (lu_resp_ready),
        .lu_resp_rd    (lu_resp_rd),
        .lu_resp_data  (lu_resp_data),
        .pipe_wb_en    (pipe_wb_en),
        .pipe_wb_rd    (pipe_wb_rd),
        .pipe_wb_data  (pipe_wb_data),
        .pipe_hold     (pipe_hold),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    // Reference model state
    bit         m_pend [32];
    long_resp_t m_buf[$];     // accepted, not yet written responses
    long_resp_t lu_q[$];      // issued ops the long unit still owes
    int         m_wait;       // cycles the buffer head has been blocked
    int         m_out;        // issued and not yet retired
    bit         wb_valid;
    bit         wb_held;
    logic [4:0] wb_rd;
    logic [31:0] wb_data;
    bit         lu_presenting;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [4:0] pick_free();
        int r;
        do r = $urandom_range(1, 31); while (m_pend[r]);
        return 5'(r);
    endfunction

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_buf.delete();
        lu_q.delete();
        m_wait = 0;
        m_out = 0;
        wb_held = 1'b0;
        wb_valid = 1'b0;
        lu_presenting = 1'b0;
    endtask

    task automatic idle_inputs();
        dec_rs = '0; dec_use_rs = '0; dec_rd = '0;
        dec_writes_rd = 1'b0; dec_is_long = 1'b0; dec_advance = 1'b0;
        lu_resp_valid = 1'b0; lu_resp_rd = '0; lu_resp_data = '0;
        pipe_wb_en = 1'b0; pipe_wb_rd = '0; pipe_wb_data = '0;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_pipe_hold"}, pipe_hold, 0);
        check({tag, "_rf_we"}, rf_we, 0);
        check({tag, "_rf_waddr"}, rf_waddr, 0);
        check({tag, "_rf_wdata"}, rf_wdata, 0);
        check({tag, "_ready"}, lu_resp_ready, 1);
    endtask

    // Monitor: every DUT RF write must match the next predicted write,
    // in the cycle it was predicted for.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                total++; bad++;
                $display("FAIL rf_missing cyc=%0d actual=no_write required=x%0d:%h", e.cyc, e.addr, e.data);
            end
            if (rf_we !== 1'b0) begin
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    total++; bad++;
                    $display("FAIL rf_unexpected cyc=%0d actual=we%b x%0d:%h required=no_write", cyc, rf_we, rf_waddr, rf_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("rf_waddr", rf_waddr, e.addr);
                    check("rf_wdata", rf_wdata, e.data);
                end
            end
        end
    end

    task automatic do_cycle(int p_pipe, int p_resp, int p_long);
        bit exp_stall, exp_hold, exp_we, exp_ready, pop, accept;
        logic [4:0]  wa, rd_eff;
        logic [31:0] wd;
        long_resp_t  h;
        wr_t         e;

        @(negedge clk);
        cyc++;

        // Pipeline writeback: a held WB is retried unchanged.
        if (!wb_held) begin
            wb_valid = ($urandom_range(99) < p_pipe);
            wb_rd    = pick_free();
            wb_data  = $urandom;
        end
        pipe_wb_en   = wb_valid;
        pipe_wb_rd   = wb_rd;
        pipe_wb_data = wb_data;

        // Decode
        for (int i = 0; i < NR; i++) begin
            dec_rs[i]     = 5'($urandom_range(0, 7));
            dec_use_rs[i] = 1'($urandom_range(1));
        end
        dec_rd        = 5'($urandom_range(0, 7));
        dec_writes_rd = 1'($urandom_range(1));
        dec_is_long   = ($urandom_range(99) < p_long);
        if ($urandom_range(9) == 0) begin
            dec_use_rs = '0; dec_writes_rd = 1'b0; dec_is_long = 1'b0;
        end
        if (dec_is_long && dec_writes_rd && wb_valid && dec_rd == wb_rd) dec_rd = 5'd0;

        exp_stall = 1'b0;
        for (int i = 0; i < NR; i++)
            if (dec_use_rs[i] && m_pend[dec_rs[i]]) exp_stall = 1'b1;
        if (dec_writes_rd && m_pend[dec_rd]) exp_stall = 1'b1;
        if (dec_is_long && m_out == MAXO) exp_stall = 1'b1;
        dec_advance = !exp_stall && ($urandom_range(3) != 0);

        // Long unit presents responses in issue order; a presented one stays.
        if (lu_q.size() > 0 && (lu_presenting || $urandom_range(99) < p_resp)) begin
            lu_presenting = 1'b1;
            lu_resp_valid = 1'b1;
            lu_resp_rd    = lu_q[0].rd;
            lu_resp_data  = lu_q[0].data;
        end else begin
            lu_resp_valid = 1'b0;
            lu_resp_rd    = 5'($urandom);
            lu_resp_data  = $urandom;
        end

        // Expected write-port decision
        exp_ready = (m_buf.size() < DEPTH);
        exp_hold = 1'b0; exp_we = 1'b0; pop = 1'b0; wa = '0; wd = '0;
        if (m_buf.size() > 0 && m_buf[0].rd == 5'd0) begin
            pop = 1'b1;
            if (wb_valid) begin exp_we = 1'b1; wa = wb_rd; wd = wb_data; end
        end else if (m_buf.size() > 0 && m_wait >= LIM) begin
            pop = 1'b1; exp_hold = 1'b1; exp_we = 1'b1; wa = m_buf[0].rd; wd = m_buf[0].data;
        end else if (wb_valid) begin
            exp_we = 1'b1; wa = wb_rd; wd = wb_data;
        end else if (m_buf.size() > 0) begin
            pop = 1'b1; exp_we = 1'b1; wa = m_buf[0].rd; wd = m_buf[0].data;
        end

        #1;
        check("stall", stall, exp_stall);
        check("pipe_hold", pipe_hold, exp_hold);
        check("lu_resp_ready", lu_resp_ready, exp_ready);
        if (exp_we) begin
            e.cyc = cyc; e.addr = wa; e.data = wd;
            exp_q.push_back(e);
        end

        @(posedge clk);
        accept = lu_resp_valid && exp_ready;
        if (pop) begin
            h = m_buf.pop_front();
            if (h.rd != 5'd0) m_pend[h.rd] = 1'b0;
            m_out--;
            m_wait = 0;
        end else if (m_buf.size() > 0) begin
            m_wait++;
        end
        if (accept) begin
            m_buf.push_back(lu_q.pop_front());
            lu_presenting = 1'b0;
        end
        if (dec_advance && dec_is_long) begin
            m_out++;
            rd_eff = dec_writes_rd ? dec_rd : 5'd0;
            if (rd_eff != 5'd0) m_pend[rd_eff] = 1'b1;
            lu_q.push_back('{rd: rd_eff, data: $urandom});
        end
        wb_held = wb_valid && exp_hold;
    endtask

    task automatic do_reset_mid();
        @(negedge clk);
        cyc++;
        reset = 1'b1;
        pipe_wb_en = 1'b1; pipe_wb_rd = 5'($urandom_range(1, 31)); pipe_wb_data = $urandom;
        lu_resp_valid = 1'b1; dec_is_long = 1'b1; dec_writes_rd = 1'b1;
        dec_use_rs = '1; dec_advance = 1'b1;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        cyc++;
        idle_inputs();
        model_reset();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_reset();
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        repeat (400) do_cycle(40, 50, 30);
        repeat (400) do_cycle(100, 80, 40);   // starvation, backpressure, limit
        do_reset_mid();
        repeat (300) do_cycle(0, 30, 60);
        repeat (200) do_cycle(100, 90, 50);
        do_reset_mid();
        repeat (300) do_cycle(40, 50, 30);
        repeat (60) do_cycle(0, 100, 0);      // drain

        @(negedge clk);
        cyc++;
        idle_inputs();
        #3;
        check("drained_stall", stall, 0);
        check("drained_ready", lu_resp_ready, 1);
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL rf_leftover actual=%0d_pending required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
